// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encodings are fixed; the unused code 2'd3 falls back to S_IDLE.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit-position counter width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign diff  = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a
// single full-subtractor cell with a registered borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
        $error("serial_subtractor: WIDTH must be in 2..32");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_d;
    logic             w_borrow_nxt;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = w_run && (r_cnt == CNT_LAST);

    full_subtractor u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_borrow),
        .diff (w_d),
        .bout (w_borrow_nxt)
    );

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Result registers only move on the final bit, so diff/bout stay stable during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_r_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (w_run) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_r_sr   <= {w_d, r_r_sr[WIDTH-1:1]};
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff <= {w_d, r_r_sr[WIDTH-1:1]};
                r_bout <= w_borrow_nxt;
            end
        end
    end

    assign busy = w_run;
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
